// File: rtl/conv2_kernel_mac_if.sv
// Bundles the start/ROM/pixel/result signals of the kernel MAC into one port.
// The master side drives requests, pixels and ROM data; the slave is the MAC.
interface conv2_kernel_mac_if;
    logic        start;
    logic [7:0]  base_addr;
    logic [7:0]  rom_addr_a;
    logic [7:0]  rom_addr_b;
    logic [15:0] rom_q_a;
    logic [15:0] rom_q_b;
    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] pix_a;
    logic [15:0] pix_b;
    logic        busy;
    logic        done;
    logic [15:0] result;

    modport master (
        output start, base_addr, rom_q_a, rom_q_b, pix_valid, pix_a, pix_b,
        input  rom_addr_a, rom_addr_b, pix_ready, busy, done, result
    );

    modport slave (
        input  start, base_addr, rom_q_a, rom_q_b, pix_valid, pix_a, pix_b,
        output rom_addr_a, rom_addr_b, pix_ready, busy, done, result
    );
endinterface

// File: rtl/conv2_kernel_mac.sv
// Kernel dot-product MAC: streams pixel pairs against a dual-port weight ROM and
// emits a saturated Q8.8 result once all ceil(KLEN/2) pairs have been consumed.
module conv2_kernel_mac #(
    parameter int KLEN  = 25,
    parameter int ACC_W = 40
) (
    input  logic              clock,
    input  logic              reset,
    conv2_kernel_mac_if.slave bus
);
    localparam int         PAIRS    = (KLEN + 1) / 2;
    localparam logic [7:0] LAST_K   = 8'(PAIRS - 1);
    localparam bit         ODD_KLEN = (KLEN % 2) == 1;
    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] RUN      = 1'b1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic [0:0]              state_q, state_d;
    logic [7:0]              k_q, k_d;
    logic [7:0]              base_q, base_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [15:0]             result_q, result_d;
    logic                    done_q, done_d;

    logic                    accept;
    logic                    lastPair;
    logic [7:0]              pairNext;
    logic [7:0]              addrA;
    logic signed [31:0]      pixA32, pixB32, romA32, romB32;
    logic signed [31:0]      prodA, prodB;
    logic signed [ACC_W-1:0] accNext, shifted;
    logic [15:0]             satResult;

    assign accept   = (state_q == RUN) && bus.pix_valid;
    assign lastPair = (k_q == LAST_K);

    // The ROM is registered, so the address must already point at the pair
    // that will be consumed next cycle for rom_q to line up with k.
    assign pairNext = accept ? k_q + 8'd1 : k_q;
    assign addrA    = (state_q == RUN) ? base_q + (pairNext << 1) : bus.base_addr;

    assign bus.rom_addr_a = addrA;
    assign bus.rom_addr_b = addrA + 8'd1;
    assign bus.pix_ready  = (state_q == RUN);
    assign bus.busy       = (state_q == RUN);
    assign bus.done       = done_q;
    assign bus.result     = result_q;

    assign pixA32 = {{16{bus.pix_a[15]}}, bus.pix_a};
    assign pixB32 = {{16{bus.pix_b[15]}}, bus.pix_b};
    assign romA32 = {{16{bus.rom_q_a[15]}}, bus.rom_q_a};
    assign romB32 = {{16{bus.rom_q_b[15]}}, bus.rom_q_b};
    assign prodA  = pixA32 * romA32;
    // An odd kernel has no real weight behind port b on its final pair.
    assign prodB  = (ODD_KLEN && lastPair) ? 32'sd0 : pixB32 * romB32;

    assign accNext = acc_q + {{(ACC_W-32){prodA[31]}}, prodA}
                           + {{(ACC_W-32){prodB[31]}}, prodB};
    assign shifted = accNext >>> 8;

    always_comb begin
        satResult = shifted[15:0];
        if (shifted > SAT_MAX) begin
            satResult = 16'h7FFF;
        end else if (shifted < SAT_MIN) begin
            satResult = 16'h8000;
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        base_d   = base_q;
        acc_d    = acc_q;
        result_d = result_q;
        done_d   = 1'b0;
        if (state_q == IDLE) begin
            if (bus.start) begin
                state_d = RUN;
                base_d  = bus.base_addr;
                k_d     = 8'd0;
                acc_d   = '0;
            end
        end else if (accept) begin
            acc_d = accNext;
            if (lastPair) begin
                result_d = satResult;
                done_d   = 1'b1;
                state_d  = IDLE;
                k_d      = 8'd0;
            end else begin
                k_d = k_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            k_q      <= 8'd0;
            base_q   <= 8'd0;
            acc_q    <= '0;
            result_q <= 16'h0000;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            base_q   <= base_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: doc/conv2_kernel_mac.md
CONV2_KERNEL_MAC -- requirements
Module: conv2_kernel_mac

Interface
REQ-001 Parameter KLEN, default 25: number of kernel weights per dot product; legal range 1..256.
REQ-002 Parameter ACC_W, default 40: accumulator width in bits, signed.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  single-cycle request to begin one dot product; sampled only in IDLE.
REQ-006 base_addr  in  8  weight-ROM address of weight 0; sampled when start is accepted.
REQ-007 rom_addr_a, rom_addr_b  out  8 each  read addresses to the dual-port kernel weight ROM.
REQ-008 rom_q_a, rom_q_b  in  16 each  ROM read data; registered, 1-cycle latency; signed Q8.8.
REQ-009 pix_valid  in  1  pixel pair available.
REQ-010 pix_ready  out  1  block can accept a pixel pair.
REQ-011 pix_a, pix_b  in  16 each  pixel pair, signed Q8.8; pix_a pairs with weight 2k and pix_b with weight 2k+1.
REQ-012 busy  out  1  high from the cycle after start acceptance until the done pulse.
REQ-013 done  out  1  one-cycle pulse when result updates.
REQ-014 result  out  16  signed Q8.8 dot product; held until the next done.

Function
REQ-015 The block SHALL have states IDLE and RUN.
REQ-016 IDLE + start: latch base_addr, clear pair index k and accumulator, go to RUN; start in RUN SHALL be ignored.
REQ-017 Pair count SHALL be P = ceil(KLEN/2); pair k uses weights at base+2k (port a) and base+2k+1 (port b).
REQ-018 Address arithmetic SHALL be modulo 256 (e.g. base 0xFF gives pair 0 addresses 0xFF, 0x00).
REQ-019 Addresses SHALL be driven combinationally from the next pair index: IDLE -> base_addr/base_addr+1; RUN -> pair k+1 when a pair is accepted this cycle, else pair k.
REQ-020 Because of REQ-019, rom_q SHALL hold the weights for the current k in every RUN cycle, including the first.
REQ-021 pix_ready SHALL be 1 exactly in RUN; a pair is accepted when pix_valid && pix_ready.
REQ-022 Accept: acc += sext(pix_a*rom_q_a) + sext(pix_b*rom_q_b); each product is a 32-bit signed Q16.16 value, sign-extended to ACC_W.
REQ-023 If KLEN is odd, the port-b product of the final pair SHALL be forced to 0, and the port-b address is don't-care.
REQ-024 Accept of pair P-1: result <= sat16(acc_next >>> 8) with arithmetic shift (truncation toward minus infinity); done=1 next cycle; state -> IDLE.
REQ-025 sat16 SHALL clamp to 0x7FFF (max) and 0x8000 (min).
REQ-026 Throughput SHALL be one pair per cycle with pix_valid held high: start at cycle 0, pairs accepted at cycles 1..P, done at cycle P+1.
REQ-027 When pix_valid is low, k, acc and the ROM addresses SHALL hold.
REQ-028 A start in the same cycle as done (state IDLE) SHALL be accepted.

Reset
REQ-029 With reset high, next edge: state IDLE, k=0, acc=0, result=0x0000, done=0, busy=0, pix_ready=0.
REQ-030 Reset SHALL override start and in-flight accepts; a RUN aborted by reset SHALL NOT produce done, and result SHALL read 0x0000.

Verification
REQ-031 ROM all 0x0100, pixels all 0x0100, KLEN=25, pix_valid constant high -> done at cycle 14, result 0x1900, 13 accepts.
REQ-032 ROM 0x7FFF, pixels 0x7FFF -> result 0x7FFF; pixel sign flipped to 0x8001 -> result 0x8000.
REQ-033 KLEN=1, weight 0xFFFF, pix_a 0x0001, pix_b 0x7FFF -> result 0xFFFF (product -1, shift floors to -1; port b ignored).
REQ-034 base_addr 0xF0, random pix_valid gaps -> address sequence 0xF0/0xF1 .. 0x08/0x09 (wraps after 0xFE/0xFF); result matches golden model; addresses hold during gaps.
REQ-035 Reset asserted at RUN pair 5 -> no done; outputs at reset values; new start then completes normally.
REQ-036 start asserted in the done cycle -> second run begins without a bubble; start during RUN ignored.
